// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: internal key code
// encoding, idle row drive and the row-select helper.
package keypad_pkg;

   // Width of the external key code (row*4 + col).
   localparam int KEY_W = 4;

   // Internal code carries a "no key" flag in the MSB.
   localparam int CODE_W = KEY_W + 1;
   localparam logic [CODE_W-1:0] KEY_NONE = 5'b1_0000;

   // All rows released (no row driven low).
   localparam logic [3:0] ROW_IDLE = 4'hF;

   // Active-low one-hot drive for the given row index.
   function automatic logic [3:0] row_select(input logic [1:0] row);
      return ~(4'b0001 << row);
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce filter for the keypad scanner. A frame value must
// repeat on DEBOUNCE_SCANS consecutive frame ends before it replaces the
// accepted value; a newly accepted key produces a one-cycle pulse.
// Optional auto-repeat is built when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_PERIOD  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              frame_end,
   input  logic [CODE_W-1:0] frame_code,
   output logic              accept,
   output logic [CODE_W-1:0] accepted,
   output logic [KEY_W-1:0]  key_code
);

   localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [STB_W-1:0] STB_MAX = STB_W'(DEBOUNCE_SCANS);

   logic [CODE_W-1:0] cand_r;
   logic [STB_W-1:0]  stable_r;
   logic [STB_W-1:0]  stable_next_s;
   logic              take_s;
   logic              rep_fire_s;

   // Next stability count and whether this frame end promotes the candidate.
   always_comb begin
      stable_next_s = stable_r;
      take_s        = 1'b0;
      if (frame_code == cand_r) begin
         if (stable_r == STB_MAX) begin
            stable_next_s = STB_MAX;
         end else begin
            stable_next_s = stable_r + STB_W'(1);
         end
      end else begin
         stable_next_s = STB_W'(1);
      end
      take_s = frame_end && (stable_next_s == STB_MAX) && (frame_code != accepted);
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   logic [15:0] rep_cnt_r;
   logic        rep_periodic_r;
   logic [15:0] rep_target_s;
   logic        held_s;

   // Repeat fires when the held-frame count reaches the current target.
   always_comb begin
      rep_target_s = rep_periodic_r ? 16'(REPEAT_PERIOD) : 16'(REPEAT_DELAY);
      held_s       = !accepted[CODE_W-1] && (frame_code == accepted);
      if (frame_end && !take_s && held_s) begin
         rep_fire_s = ((rep_cnt_r + 16'd1) == rep_target_s);
      end else begin
         rep_fire_s = 1'b0;
      end
   end

   // Count frame ends while the accepted key stays held; clear otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt_r      <= 16'd0;
         rep_periodic_r <= 1'b0;
      end else if (!en) begin
         rep_cnt_r      <= 16'd0;
         rep_periodic_r <= 1'b0;
      end else if (frame_end) begin
         if (take_s || !held_s) begin
            rep_cnt_r      <= 16'd0;
            rep_periodic_r <= 1'b0;
         end else if (rep_fire_s) begin
            rep_cnt_r      <= 16'd0;
            rep_periodic_r <= 1'b1;
         end else begin
            rep_cnt_r      <= rep_cnt_r + 16'd1;
         end
      end
   end
`else
   logic [31:0] unused_repeat_cfg_s;
   assign unused_repeat_cfg_s = 32'(REPEAT_DELAY + REPEAT_PERIOD);
   assign rep_fire_s = 1'b0;
`endif

   // Candidate tracking, acceptance and the one-cycle key pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cand_r   <= KEY_NONE;
         stable_r <= '0;
         accepted <= KEY_NONE;
         accept   <= 1'b0;
         key_code <= 4'd0;
      end else if (!en) begin
         cand_r   <= KEY_NONE;
         stable_r <= '0;
         accepted <= KEY_NONE;
         accept   <= 1'b0;
      end else begin
         accept <= 1'b0;
         if (frame_end) begin
            cand_r   <= frame_code;
            stable_r <= stable_next_s;
            if (take_s) begin
               accepted <= frame_code;
               if (!frame_code[CODE_W-1]) begin
                  accept   <= 1'b1;
                  key_code <= frame_code[KEY_W-1:0];
               end
            end else if (rep_fire_s) begin
               accept <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/keypad_scan_unit.sv
// 4x4 matrix keypad scanner. Drives one row low per dwell period, samples
// the synchronised active-low columns at the end of each dwell, reduces a
// whole frame to the lowest pressed key code and hands it to the debounce
// filter. Auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scan_unit
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_PERIOD  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       col_in,
   output logic [3:0]       row_out,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             key_down
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [3:0]        col_meta_r;
   logic [3:0]        col_sync_r;
   logic [CNT_W-1:0]  count_r;
   logic [1:0]        row_r;
   logic [3:0]        row_out_r;
   logic [CODE_W-1:0] frame_acc_r;
   logic              tick_s;
   logic              frame_end_s;
   logic [CODE_W-1:0] row_hit_s;
   logic [CODE_W-1:0] base_s;
   logic [CODE_W-1:0] frame_code_s;
   logic [CODE_W-1:0] accepted_s;

   assign tick_s      = en && (count_r == CNT_LAST);
   assign frame_end_s = tick_s && (row_r == 2'd3);

   // Two-flop synchroniser for the asynchronous column inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_meta_r <= 4'hF;
         col_sync_r <= 4'hF;
      end else begin
         col_meta_r <= col_in;
         col_sync_r <= col_meta_r;
      end
   end

   // Lowest low column of the current row, and the running frame value.
   always_comb begin
      casez (col_sync_r)
         4'b???0: row_hit_s = {1'b0, row_r, 2'd0};
         4'b??01: row_hit_s = {1'b0, row_r, 2'd1};
         4'b?011: row_hit_s = {1'b0, row_r, 2'd2};
         4'b0111: row_hit_s = {1'b0, row_r, 2'd3};
         default: row_hit_s = KEY_NONE;
      endcase
      base_s       = (row_r == 2'd0) ? KEY_NONE : frame_acc_r;
      frame_code_s = base_s[CODE_W-1] ? row_hit_s : base_s;
   end

   // Dwell counter, row index, registered row drive and frame accumulator.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r     <= '0;
         row_r       <= 2'd0;
         row_out_r   <= ROW_IDLE;
         frame_acc_r <= KEY_NONE;
      end else if (!en) begin
         count_r     <= '0;
         row_r       <= 2'd0;
         row_out_r   <= ROW_IDLE;
         frame_acc_r <= KEY_NONE;
      end else if (tick_s) begin
         count_r     <= '0;
         row_r       <= row_r + 2'd1;
         row_out_r   <= row_select(row_r + 2'd1);
         frame_acc_r <= frame_code_s;
      end else begin
         count_r     <= count_r + CNT_W'(1);
         row_out_r   <= row_select(row_r);
      end
   end

   keypad_debounce #(
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
   ) u_debounce (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .frame_end  (frame_end_s),
      .frame_code (frame_code_s),
      .accept     (key_valid),
      .accepted   (accepted_s),
      .key_code   (key_code)
   );

   assign row_out  = row_out_r;
   assign key_down = ~accepted_s[CODE_W-1];

endmodule
